// File: rtl/audio_sample_fifo.sv
// Audio sample buffer with a fractional-rate output strobe for the HDMI pixel-clock domain.
// Input words are absorbed by a small FIFO and replayed at SAMPLERATE, with priming, underrun hold and overflow drop.
module audio_sample_fifo #(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 3,
    parameter int SAMPLERATE = 48000,
    parameter int CLKRATE    = 74250000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      in_stb,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_stb,
    output logic [DEPTH_LOG2:0]       level,
    output logic                      underrun,
    output logic                      overflow,
    input  logic                      clr_flags
);

    localparam int DW    = CHANNELS * WIDTH;
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [31:0]         C_SAMPLERATE = 32'(SAMPLERATE);
    localparam logic [31:0]         C_CLKRATE    = 32'(CLKRATE);
    localparam logic [DEPTH_LOG2:0] C_DEPTH      = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] C_HALF       = (DEPTH_LOG2 + 1)'(DEPTH / 2);

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                r_state;
    logic [31:0]           r_acc;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [DW-1:0]         r_out_data;
    logic                  r_out_stb;
    logic                  r_underrun;
    logic                  r_overflow;
    logic [DW-1:0]         r_mem [DEPTH];

    state_t      w_state_next;
    logic [31:0] w_acc_sum;
    logic        w_tick;
    logic        w_rd_en;
    logic        w_wr_en;
    logic        w_wr_drop;
    logic        w_underrun_set;

    // CLKRATE < 2**31 keeps acc + SAMPLERATE inside 32 bits.
    always_comb begin
        w_acc_sum = r_acc + C_SAMPLERATE;
        w_tick    = (w_acc_sum >= C_CLKRATE);
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_next   = r_state;
        w_rd_en        = 1'b0;
        w_underrun_set = 1'b0;
        case (r_state)
            ST_PRIME: begin
                if (r_level >= C_HALF) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_tick) begin
                    if (r_level != '0) begin
                        w_rd_en = 1'b1;
                    end else begin
                        w_underrun_set = 1'b1;
                        w_state_next   = ST_PRIME;
                    end
                end
            end
            default: w_state_next = ST_PRIME;
        endcase
    end

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    always_comb begin
        w_wr_en   = in_stb && ((r_level != C_DEPTH) || w_rd_en);
        w_wr_drop = in_stb && !w_wr_en;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_PRIME;
            r_acc      <= '0;
            r_out_stb  <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_state   <= w_state_next;
            r_acc     <= w_tick ? (w_acc_sum - C_CLKRATE) : w_acc_sum;
            r_out_stb <= w_tick;
            if (w_rd_en) begin
                r_out_data <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Setting a flag takes priority over clearing it in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end else if (clr_flags) begin
                r_underrun <= 1'b0;
            end
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // NOTE: storage has no reset; only the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    assign out_data = r_out_data;
    assign out_stb  = r_out_stb;
    assign level    = r_level;
    assign underrun = r_underrun;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: a 1:10 rate instance for FIFO behaviour
// and a 74.25 MHz / 48 kHz instance for tick spacing.
module tb_audio_sample_fifo;

    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_stb;
    logic          clr_flags;
    logic [DW-1:0] out_data;
    logic          out_stb;
    logic [3:0]    level;
    logic          underrun;
    logic          overflow;

    logic [DW-1:0] hd_out_data;
    logic          hd_out_stb;
    logic [3:0]    hd_level;
    logic          hd_underrun;
    logic          hd_overflow;

    int total = 0;
    int bad   = 0;

    audio_sample_fifo #(
        .CHANNELS(2), .WIDTH(16), .DEPTH_LOG2(3), .SAMPLERATE(48000), .CLKRATE(480000)
    ) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_stb(in_stb),
        .out_data(out_data), .out_stb(out_stb), .level(level),
        .underrun(underrun), .overflow(overflow), .clr_flags(clr_flags)
    );

    audio_sample_fifo #(
        .CHANNELS(2), .WIDTH(16), .DEPTH_LOG2(3), .SAMPLERATE(48000), .CLKRATE(74250000)
    ) u_dut_hd (
        .clk(clk), .reset(reset), .in_data(32'h0), .in_stb(1'b0),
        .out_data(hd_out_data), .out_stb(hd_out_stb), .level(hd_level),
        .underrun(hd_underrun), .overflow(hd_overflow), .clr_flags(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one word for one cycle, starting and ending at a falling edge.
    task automatic write_word(input logic [DW-1:0] d);
        in_data = d;
        in_stb  = 1'b1;
        @(negedge clk);
        in_stb  = 1'b0;
    endtask

    // Advance to the next falling edge where out_stb is high, bounded by limit cycles.
    task automatic wait_stb(input string tag, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_stb && n < limit);
        check(tag, out_stb, 1'b1);
    endtask

    initial begin
        int     first_k;
        int     last_k;
        int     pulses;
        int     sp;
        longint exp_pulses;

        reset     = 1'b1;
        in_data   = '0;
        in_stb    = 1'b0;
        clr_flags = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_out_data", out_data, 32'h0);
        check("rst_out_stb",  out_stb,  1'b0);
        check("rst_level",    level,    4'd0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_overflow", overflow, 1'b0);

        // Step 1: idle, strobe every 10 cycles.
        reset = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            check($sformatf("t1_stb_k%0d", k), out_stb, (k % 10 == 0));
        end
        check("t1_out_data", out_data, 32'h0);
        check("t1_underrun", underrun, 1'b0);
        check("t1_level",    level,    4'd0);

        // Step 2: four words, prime, replay, then underrun.
        for (int i = 1; i <= 4; i++) begin
            write_word({16'(i), 16'(i)});
        end
        check("t2_level_full", level, 4'd4);
        for (int i = 1; i <= 4; i++) begin
            wait_stb("t2_stb", 20);
            check($sformatf("t2_data_%0d", i),  out_data, {16'(i), 16'(i)});
            check($sformatf("t2_level_%0d", i), level,    4'(4 - i));
        end
        wait_stb("t2_ur_stb", 20);
        check("t2_underrun", underrun, 1'b1);
        check("t2_hold",     out_data, 32'h0004_0004);
        check("t2_ur_level", level,    4'd0);

        // Step 3: nine writes between ticks, ninth dropped.
        for (int i = 1; i <= 9; i++) begin
            write_word({16'hA000 + 16'(i), 16'hB000 + 16'(i)});
        end
        check("t3_level",    level,    4'd8);
        check("t3_overflow", overflow, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            wait_stb("t3_stb", 20);
            check($sformatf("t3_data_%0d", i),  out_data, {16'hA000 + 16'(i), 16'hB000 + 16'(i)});
            check($sformatf("t3_level_%0d", i), level,    4'(8 - i));
        end
        wait_stb("t3_ur_stb", 20);
        check("t3_underrun", underrun, 1'b1);
        check("t3_hold",     out_data, 32'hA008_B008);

        // Step 5a: clear both flags.
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("t5_clr_underrun", underrun, 1'b0);
        check("t5_clr_overflow", overflow, 1'b0);

        // Step 4: fill to 8, then write on the tick cycle.
        for (int i = 1; i <= 8; i++) begin
            write_word({16'hC000 + 16'(i), 16'hD000 + 16'(i)});
        end
        check("t4_level_pre", level, 4'd8);
        in_data = 32'hCAFE_F00D;
        in_stb  = 1'b1;
        @(negedge clk);
        in_stb  = 1'b0;
        check("t4_stb",      out_stb,  1'b1);
        check("t4_data",     out_data, 32'hC001_D001);
        check("t4_level",    level,    4'd8);
        check("t4_overflow", overflow, 1'b0);

        // Step 5b: overflow write and clear together, set wins.
        in_data   = 32'hDEAD_BEEF;
        in_stb    = 1'b1;
        clr_flags = 1'b1;
        @(negedge clk);
        in_stb    = 1'b0;
        clr_flags = 1'b0;
        check("t5_set_wins", overflow, 1'b1);
        check("t5_level",    level,    4'd8);
        for (int i = 2; i <= 8; i++) begin
            wait_stb("t5_stb", 20);
            check($sformatf("t5_data_%0d", i),  out_data, {16'hC000 + 16'(i), 16'hD000 + 16'(i)});
            check($sformatf("t5_level_%0d", i), level,    4'(9 - i));
        end
        wait_stb("t5_last_stb", 20);
        check("t5_last_data",  out_data, 32'hCAFE_F00D);
        check("t5_last_level", level,    4'd0);

        // Asynchronous reset mid-operation.
        write_word(32'h1111_2222);
        write_word(32'h3333_4444);
        check("rst2_pre_level", level, 4'd2);
        #2 reset = 1'b1;
        #1;
        check("rst2_level",    level,    4'd0);
        check("rst2_out_data", out_data, 32'h0);
        check("rst2_overflow", overflow, 1'b0);
        check("rst2_underrun", underrun, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Step 6: 74.25 MHz / 48 kHz spacing and count over a bounded window.
        reset   = 1'b0;
        first_k = 0;
        last_k  = 0;
        pulses  = 0;
        for (int k = 1; k <= 60000; k++) begin
            @(negedge clk);
            if (hd_out_stb) begin
                pulses++;
                if (first_k == 0) begin
                    first_k = k;
                end else begin
                    sp = k - last_k;
                    check($sformatf("t6_spacing_k%0d_sp%0d", k, sp), (sp == 1546 || sp == 1547), 1'b1);
                end
                last_k = k;
            end
        end
        exp_pulses = (longint'(60000) * 48000) / 74250000;
        check("t6_first", first_k, 64'(((74250000 + 48000 - 1) / 48000)));
        check("t6_count", pulses, exp_pulses);
        check("t6_level",    hd_level,    4'd0);
        check("t6_out_data", hd_out_data, 32'h0);
        check("t6_underrun", hd_underrun, 1'b0);
        check("t6_overflow", hd_overflow, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_sample_fifo.md
Name: audio_sample_fifo

Overview:
- Single-clock, parametrised audio sample buffer and rate generator in the HDMI pixel-clock domain.
- Accepts N-channel sample words on an input strobe, buffers them in a small FIFO, and replays them on a fractional-rate output strobe.
- The output strobe is derived from CLKRATE/SAMPLERATE and is uniform in time; input strobe jitter is absorbed by the FIFO.
- Adds priming, underrun sample-hold, overflow drop, fill level and sticky error flags. It sits between the clock-domain restrobe stage and the HDMI audio packetiser.

Parameters:
CHANNELS, 2, number of audio channels; channel 0 occupies the MSBs of each word.
WIDTH, 16, bits per channel sample.
DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 words (minimum 2).
SAMPLERATE, 48000, output sample rate in Hz.
CLKRATE, 74250000, clk frequency in Hz; must be > SAMPLERATE and < 2**31.

Ports:
clk  in  1  pixel clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
in_data  in  CHANNELS*WIDTH  input sample word.
in_stb  in  1  one-cycle write strobe; in_data is valid in the same cycle.
out_data  out  CHANNELS*WIDTH  output sample word; registered.
out_stb  out  1  one-cycle strobe at SAMPLERATE; marks a new out_data.
level  out  DEPTH_LOG2+1  current FIFO occupancy, 0..DEPTH.
underrun  out  1  sticky underrun flag.
overflow  out  1  sticky overflow flag.
clr_flags  in  1  synchronous clear of underrun and overflow.

Behaviour:
- Reset values: out_data=0, out_stb=0, level=0, underrun=0, overflow=0, accumulator=0, read/write pointers=0, state=PRIME.
- Rate generator:
  - 32-bit accumulator acc. Each cycle, if acc+SAMPLERATE >= CLKRATE: tick=1 and acc <= acc+SAMPLERATE-CLKRATE; else acc <= acc+SAMPLERATE.
  - Long-term tick rate is exactly SAMPLERATE; tick spacing jitter is at most 1 cycle.
- Output timing:
  - Every tick cycle T drives out_stb=1 in cycle T+1 (registered). out_stb never depends on FIFO state.
  - out_data updates at the same edge.
- State PRIME:
  - On tick, out_data holds its previous value.
  - Move to RUN when level >= DEPTH/2, evaluated each cycle on the registered level.
- State RUN, on tick:
  - If level>0: out_data <= FIFO head, read pointer advances, level decrements.
  - If level==0: out_data holds, underrun <= 1, state <= PRIME. A write in the same cycle is not readable that cycle.
- Write:
  - in_stb stores in_data at the write pointer when level<DEPTH, or when a read occurs in the same cycle.
  - Otherwise the write is dropped and overflow <= 1; stored contents are unchanged.
- Simultaneous read and write: both happen and level is unchanged.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
- clr_flags clears both flags. If a set condition occurs in the same cycle, the set wins.
- Reset asserted mid-operation returns everything to reset values immediately; FIFO contents are don't-care.

Test Plan (SAMPLERATE=48000, CLKRATE=480000, DEPTH_LOG2=3, CHANNELS=2, WIDTH=16):
1. Release reset, no input for 100 cycles -> out_stb pulses exactly every 10 cycles; out_data=0; underrun=0; level=0.
2. Write 0x0001_0001..0x0004_0004 back-to-back -> level reaches 4 and state enters RUN. Outputs are 0x0001_0001..0x0004_0004 on successive out_stb; level returns to 0. The next tick sets underrun=1 and out_data holds 0x0004_0004.
3. Write 9 words with no intervening tick -> level=8, overflow=1, the 9th word is dropped. Draining yields the first 8 words in order.
4. Level=8 in RUN, in_stb on a tick cycle -> write accepted, level stays 8, overflow stays 0.
5. Set both flags, pulse clr_flags alone -> both flags 0. Pulse clr_flags on the same cycle as an overflow write -> overflow=1.
6. CLKRATE=74250000, SAMPLERATE=48000, run 74250000 cycles -> exactly 48000 out_stb pulses; consecutive spacing is 1546 or 1547 cycles.
